pulse_burst_gen: RTL
====================

# pulse_burst_gen

Registered pulse-train transmitter that emits a programmed number of clean, fixed-width pulses on request. It is the driving end of the pulse interface consumed by ripple_carry_counter and push_sw. It replaces the free-running pulse source wherever a bench or board needs an exact, known pulse count. A start/busy/done handshake lets a controller or testbench request bursts of 0–15 pulses and check the count downstream.

## Interface
- HIGH_CYC, 2, i_clk cycles o_pulse stays high per pulse; legal range ≥1
- LOW_CYC, 2, i_clk cycles o_pulse stays low after each pulse (inter-pulse and trailing gap); legal range ≥1
- CNT_W, 4, width of burst length and sent counter
- i_clk  in  1  single system clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  burst request, sampled on rising edge of i_clk; level, not edge
- i_count  in  CNT_W  pulses to send; sampled only when a start is accepted
- o_pulse  out  1  pulse train, driven directly from a flop (glitch-free, usable as a clock by ripple_carry_counter)
- o_busy  out  1  high while a burst is in progress
- o_done  out  1  one-cycle strobe at burst completion
- o_sent  out  CNT_W  pulses completed in current/last burst

## Operation
- States: IDLE, HIGH, LOW, DONE. One timer counts cycles within HIGH/LOW. Timer width holds max(HIGH_CYC, LOW_CYC).
- Start accept: i_start=1 while state is IDLE or DONE (o_busy=0). On accept:
  - latch i_count into the internal length register;
  - clear o_sent;
  - next state is HIGH if i_count≠0, else DONE.
- i_start while o_busy=1 is ignored. i_count changes during a burst have no effect.
- HIGH: o_pulse=1 for HIGH_CYC cycles, then go to LOW. o_sent increments by 1 on that HIGH→LOW edge.
- LOW: o_pulse=0 for LOW_CYC cycles. Next state:
  - HIGH if o_sent < latched length;
  - DONE otherwise.
- Every pulse, including the last, is followed by a full LOW gap.
- DONE: o_done=1 for exactly one cycle, then IDLE. A start accepted in this cycle goes directly to HIGH (or DONE if count=0); it does not pass through IDLE.
- o_busy=1 exactly in HIGH and LOW states.
- o_sent holds its final value after completion until the next accepted start. It never wraps within a burst, because the length is ≤ 2^CNT_W−1.
- Reset values (asynchronous, immediate on i_rst_n=0, including mid-burst):
  - state=IDLE;
  - o_pulse=0, o_busy=0, o_done=0;
  - o_sent=0;
  - timer and latched length=0.
- Mid-burst reset truncates the burst with no o_done.
- After i_rst_n deasserts, the first i_start is honoured on the next rising edge.

## Timing
- Start sampled at edge 0. o_pulse rises at edge 1, so latency is 1 cycle.
- Pulse k (1-based) is high during cycles 1+(k−1)(H+L) through (k−1)(H+L)+H, where H=HIGH_CYC and L=LOW_CYC.
- o_busy is high for cycles 1 through N(H+L). o_done is high in cycle N(H+L)+1.
- N=0: o_done is high in cycle 1, o_busy never rises, o_pulse stays 0.
- o_sent=k from cycle (k−1)(H+L)+H+1 onward.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Defaults, i_count=3 start pulse at cycle 0 → o_pulse high cycles 1–2, 5–6, 9–10; o_sent=1,2,3 at cycles 3,7,11; o_busy cycles 1–12; o_done only in cycle 13; downstream ripple_carry_counter o_q=3.
- i_count=0 → o_done in cycle 1; o_pulse and o_busy stay 0; o_sent=0.
- i_count=15, H=1, L=1 → 15 pulses; o_done in cycle 31; o_sent=15; counter o_q=15 with no wrap.
- i_start held high continuously, i_count=2 → second burst accepted in the DONE cycle (cycle 9); its first pulse is at cycle 10; i_count changed to 7 mid-burst has no effect.
- i_start pulses at cycles 3 and 6 during a count-3 burst → ignored; burst timing is identical to the first test.
- i_rst_n low at cycle 6 (mid-pulse) → o_pulse, o_busy, o_sent=0 immediately; no o_done. After release, a new start with i_count=1 gives a pulse in the 2 cycles after the accepting edge and o_done 4 cycles later.

Source files
------------

// File: rtl/pulse_burst_gen.sv
// Registered pulse-train transmitter: on request emits i_count pulses of HIGH_CYC
// cycles separated by LOW_CYC-cycle gaps, with start/busy/done handshake.
module pulse_burst_gen #(
  parameter int unsigned HIGH_CYC = 2,
  parameter int unsigned LOW_CYC  = 2,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_sent
);

  localparam int unsigned MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] H_LAST = TMR_W'(HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] L_LAST = TMR_W'(LOW_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] len, len_n;
  logic [CNT_W-1:0] sent, sent_n;
  logic             accept;

  always_comb begin
    state_n = state;
    timer_n = timer;
    len_n   = len;
    sent_n  = sent;
    accept  = i_start && ((state == S_IDLE) || (state == S_DONE));

    case (state)
      S_HIGH: begin
        if (timer == H_LAST) begin
          state_n = S_LOW;
          timer_n = '0;
          sent_n  = sent + 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_LOW: begin
        if (timer == L_LAST) begin
          timer_n = '0;
          state_n = (sent < len) ? S_HIGH : S_DONE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (accept) begin
      len_n   = i_count;
      sent_n  = '0;
      timer_n = '0;
      state_n = (i_count != '0) ? S_HIGH : S_DONE;
    end
  end

  // Outputs are flopped decodes of the current state, so they trail the state by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      len     <= '0;
      sent    <= '0;
      o_pulse <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sent  <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      len     <= len_n;
      sent    <= sent_n;
      o_pulse <= (state == S_HIGH);
      o_busy  <= (state == S_HIGH) || (state == S_LOW);
      o_done  <= (state == S_DONE);
      o_sent  <= sent;
    end
  end

endmodule
